// File: rtl/gesture_pkg.sv
// rtl/gesture_pkg.sv - shared types and constants for the gesture scheduler
package gesture_pkg;

    localparam int DEFAULT_GESTURE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Rest pose; also the gesture presented after reset.
    localparam logic [DEFAULT_GESTURE_W-1:0] GESTURE_REST = '0;

endpackage

// File: rtl/gesture_rr_arbiter.sv
// rtl/gesture_rr_arbiter.sv - combinational request arbiter (round-robin when GESTURE_SCHED_RR_EN, else fixed priority)
module gesture_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef GESTURE_SCHED_RR_EN
    input  logic [IDX_W-1:0]   pointer,
`endif
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx
);
    import gesture_pkg::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] cand;
    logic             found;

`ifdef GESTURE_SCHED_RR_EN
    // Search begins just after the last winner, wrapping at NUM_REQ.
    assign start = (pointer == LAST) ? '0 : pointer + IDX_W'(1);
`else
    // Fixed priority: search always begins at source 0.
    assign start = '0;
`endif

    // Walk the sources from start, wrapping, and take the first one asserted.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = start;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[cand]) begin
                found       = 1'b1;
                winner[cand] = 1'b1;
                idx         = cand;
            end
            cand = (cand == LAST) ? '0 : cand + IDX_W'(1);
        end
    end

endmodule

// File: rtl/gesture_scheduler.sv
// rtl/gesture_scheduler.sv - one-at-a-time gesture forwarding with settle hold; GESTURE_SCHED_RR_EN selects round-robin
module gesture_scheduler
    import gesture_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int GESTURE_W   = DEFAULT_GESTURE_W,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*GESTURE_W-1:0] req_gesture,
    output logic [NUM_REQ-1:0]           grant,
    output logic [GESTURE_W-1:0]         gesture,
    output logic                         gesture_update,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   active_src
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [GESTURE_W-1:0] gesture_next;
    logic [NUM_REQ-1:0]   grant_next;
    logic                 update_next;
    logic [IDX_W-1:0]     src_next;
    logic [NUM_REQ-1:0]   winner;
    logic [IDX_W-1:0]     win_idx;
    logic [GESTURE_W-1:0] sel_code;

`ifdef GESTURE_SCHED_RR_EN
    logic [IDX_W-1:0]     ptr, ptr_next;

    gesture_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req),
        .pointer (ptr),
        .winner  (winner),
        .idx     (win_idx)
    );
`else
    gesture_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req),
        .winner  (winner),
        .idx     (win_idx)
    );
`endif

    // Pick the winning source's gesture code out of the flattened bus.
    always_comb begin
        sel_code = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                sel_code = req_gesture[i*GESTURE_W +: GESTURE_W];
            end
        end
    end

    // Next-state logic: accept a request in IDLE, count down the settle time in HOLD.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        gesture_next = gesture;
        grant_next   = '0;
        update_next  = 1'b0;
        src_next     = active_src;
`ifdef GESTURE_SCHED_RR_EN
        ptr_next     = ptr;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_next = winner;
                    src_next   = win_idx;
`ifdef GESTURE_SCHED_RR_EN
                    ptr_next   = win_idx;
`endif
                    // A repeat of the current pose is acknowledged but not re-applied.
                    if (sel_code != gesture) begin
                        gesture_next = sel_code;
                        update_next  = 1'b1;
                        cnt_next     = CNT_W'(HOLD_CYCLES - 1);
                        state_next   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            gesture        <= GESTURE_W'(GESTURE_REST);
            grant          <= '0;
            gesture_update <= 1'b0;
            active_src     <= '0;
`ifdef GESTURE_SCHED_RR_EN
            ptr            <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            gesture        <= gesture_next;
            grant          <= grant_next;
            gesture_update <= update_next;
            active_src     <= src_next;
`ifdef GESTURE_SCHED_RR_EN
            ptr            <= ptr_next;
`endif
        end
    end

    assign busy = (state == HOLD);

endmodule

// File: tb/tb_gesture_scheduler.sv
// tb/tb_gesture_scheduler.sv - directed self-checking bench for gesture_scheduler (NUM_REQ=3, HOLD_CYCLES=4)
module tb_gesture_scheduler;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [7:0]  c0, c1, c2;
    logic [23:0] req_gesture;
    logic [2:0]  grant;
    logic [7:0]  gesture;
    logic        gesture_update;
    logic        busy;
    logic [1:0]  active_src;

    int vectors;
    int miscompares;

    assign req_gesture = {c2, c1, c0};

    gesture_scheduler #(
        .NUM_REQ     (3),
        .GESTURE_W   (8),
        .HOLD_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_gesture    (req_gesture),
        .grant          (grant),
        .gesture        (gesture),
        .gesture_update (gesture_update),
        .busy           (busy),
        .active_src     (active_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] g, input logic [7:0] ges,
                             input logic upd, input logic bsy, input logic [1:0] src);
        check({tag, ".grant"},   32'(grant),          32'(g));
        check({tag, ".gesture"}, 32'(gesture),        32'(ges));
        check({tag, ".update"},  32'(gesture_update), 32'(upd));
        check({tag, ".busy"},    32'(busy),           32'(bsy));
        check({tag, ".src"},     32'(active_src),     32'(src));
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && busy; n++) step();
        check("wait_idle", 32'(busy), 32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        req = 3'b000;
        c0  = 8'h00;
        c1  = 8'h00;
        c2  = 8'h00;

        // Reset values
        step();
        step();
        check_all("reset", 3'b000, 8'h00, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;

        // Idle with no requests
        step();
        check_all("idle", 3'b000, 8'h00, 1'b0, 1'b0, 2'd0);

        // Source 1 requests 0x2A
        req = 3'b010;
        c1  = 8'h2A;
        step();
        check_all("first", 3'b010, 8'h2A, 1'b1, 1'b1, 2'd1);
        req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("hold", 3'b000, 8'h2A, 1'b0, 1'b1, 2'd1);
        end
        step();
        check("busy_len", 32'(busy), 32'h0);

        // Duplicate from source 2, held for two cycles -> two grants, no update
        req = 3'b100;
        c2  = 8'h2A;
        step();
        check_all("dup1", 3'b100, 8'h2A, 1'b0, 1'b0, 2'd2);
        step();
        check_all("dup2", 3'b100, 8'h2A, 1'b0, 1'b0, 2'd2);
        req = 3'b000;
        step();
        check("dup_end.grant", 32'(grant), 32'h0);

        // All three request with distinct codes
        c0  = 8'h11;
        c1  = 8'h22;
        c2  = 8'h33;
        req = 3'b111;
        step();
        check_all("all", 3'b001, 8'h11, 1'b1, 1'b1, 2'd0);
`ifndef GESTURE_SCHED_RR_EN
        // Only source 1 remains pending through the hold
        req = 3'b010;
`endif
        for (int i = 0; i < 4; i++) begin
            step();
            check("pending.grant", 32'(grant), 32'h0);
        end
        check("pending.busy", 32'(busy), 32'h0);
        step();
        check_all("pend_grant", 3'b010, 8'h22, 1'b1, 1'b1, 2'd1);
`ifdef GESTURE_SCHED_RR_EN
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr.gap", 32'(grant), 32'h0);
        end
        step();
        check_all("rr_third", 3'b100, 8'h33, 1'b1, 1'b1, 2'd2);
`endif
        req = 3'b000;
        wait_idle();

        // Back-to-back distinct codes from source 0: updates 5 cycles apart
        req = 3'b001;
        c0  = 8'h40;
        step();
        check_all("b2b1", 3'b001, 8'h40, 1'b1, 1'b1, 2'd0);
        c0 = 8'h41;
        for (int i = 0; i < 4; i++) begin
            step();
            check("b2b.gap", 32'(gesture_update), 32'h0);
        end
        step();
        check_all("b2b2", 3'b001, 8'h41, 1'b1, 1'b1, 2'd0);
        req = 3'b000;
        wait_idle();

        // Reset two cycles into hold; pending request re-granted after release
        req = 3'b010;
        c1  = 8'h55;
        step();
        check_all("pre_rst", 3'b010, 8'h55, 1'b1, 1'b1, 2'd1);
        step();
        step();
        rst = 1'b1;
        #1;
        check_all("mid_rst", 3'b000, 8'h00, 1'b0, 1'b0, 2'd0);
        step();
        rst = 1'b0;
        step();
        check_all("post_rst", 3'b010, 8'h55, 1'b1, 1'b1, 2'd1);
        req = 3'b000;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gesture_scheduler.md
# gesture_scheduler

Arbitrates gesture requests from several sources (debounced button/switch capture, UART command decoder, EMG classifier) and forwards one gesture at a time to the servo drive stage. Each applied gesture is held for a programmable settle time before another is accepted, so the arm finishes one pose before the next is commanded. Sits between the gesture source blocks and the servo PWM/position controller.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- GESTURE_W, 8, gesture code width
- HOLD_CYCLES, 50_000_000, settle time in clk cycles after a gesture change (>= 1; 1 s at 50 MHz)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-source request level
- req_gesture  in  NUM_REQ*GESTURE_W  flattened codes; source i at bits [i*GESTURE_W +: GESTURE_W]
- grant  out  NUM_REQ  one-hot, single-cycle acknowledge
- gesture  out  GESTURE_W  currently applied gesture
- gesture_update  out  1  single-cycle pulse when gesture changes
- busy  out  1  high while in HOLD
- active_src  out  $clog2(NUM_REQ)  index of the source that supplied gesture

## Operation
- Reset values: gesture=0, grant=0, gesture_update=0, busy=0, active_src=0, state IDLE, hold counter 0, arbitration pointer NUM_REQ-1.
- States: IDLE, HOLD.
- IDLE, no req bit set: stay IDLE, all pulses low.
- IDLE, any req set: winner w chosen by arbitration; on that edge grant[w]=1 for one cycle, active_src=w.
  - req_gesture[w] != gesture: gesture latched, gesture_update=1 same cycle, counter loaded HOLD_CYCLES-1, go HOLD, busy=1.
  - req_gesture[w] == gesture: grant only, no gesture_update, stay IDLE (duplicate suppression, no settle time).
- HOLD: req ignored, grant=0. Counter decrements each cycle; at 0 return IDLE, busy=0.
- Handshake: requester keeps req and its code stable until it sees grant, then deasserts req the next cycle. A req still high one cycle after grant is treated as a new request.
- Arbitration (default, fixed priority): lowest set index wins.
- Requests arriving during HOLD are not lost; they stay pending on req and compete on the first IDLE cycle.
- Reset asserted mid-HOLD: immediate return to reset values; pending requests re-arbitrated after release.

## Timing
- Request sampled at edge k in IDLE -> grant, gesture, gesture_update, active_src valid after edge k (1-cycle latency, registered outputs).
- gesture_update and grant each high exactly one cycle.
- busy high for exactly HOLD_CYCLES cycles following the update edge.
- Minimum spacing between two gesture_update pulses: HOLD_CYCLES+1 cycles.
- Duplicate grants can be issued on consecutive cycles.

## Configuration
- GESTURE_SCHED_RR_EN defined: round-robin arbitration; search starts at (pointer+1) mod NUM_REQ, wrapping; pointer updated to winner on every grant (including duplicates).
- Undefined: fixed priority, lowest index wins; pointer register absent.

## Structure
- Shared package gesture_pkg: GESTURE_W default, state enum (IDLE, HOLD), reserved code GESTURE_REST = 0.
- One sub-module: gesture_rr_arbiter (combinational; inputs req, pointer; outputs one-hot winner and index; fixed-priority path when GESTURE_SCHED_RR_EN undefined).
- Hold counter width $clog2(HOLD_CYCLES+1).

## Test plan
Bench uses NUM_REQ=3, HOLD_CYCLES=4.
- Reset, then req=3'b010 with code 0x2A -> grant=3'b010 one cycle later, gesture=0x2A, gesture_update pulse, active_src=1, busy high 4 cycles.
- req=3'b111 all distinct codes in fixed-priority build -> source 0 granted first; with GESTURE_SCHED_RR_EN, sources held high get grants in order 0,1,2 spaced 5 cycles.
- Source 2 requests code equal to current gesture 0x2A -> grant[2] pulse, no gesture_update, busy stays 0.
- req from source 1 raised during HOLD -> no grant until busy falls, then grant on the first IDLE edge.
- Assert rst two cycles into HOLD -> gesture=0, busy=0, grant=0 immediately; after release pending req re-granted.
- Back-to-back distinct requests from one source -> gesture_update pulses exactly 5 cycles apart.
